// File: rtl/fmap_storage_buf.sv
// ---------------------------------------------------------------------------
// fmap_storage_buf
//
// Feature-map frame buffer between a conv engine and the next layer. One full
// frame of CH*FH*FW words is captured LANES words per beat at consecutive
// addresses, then streamed back out in the same order, LANES words per beat.
// Lane 0 always sits in the MSBs of a beat and maps to the lowest address.
//
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset
//   soft_clr    synchronous clear back to IDLE (highest synchronous priority)
//   in_valid    write beat valid
//   in_ready    write beat accepted when in_valid & in_ready
//   in_data     LANES*DATA_W write beat
//   frame_full  frame captured, waiting for (or during) readout
//   rd_start    one-cycle pulse, starts readout when the frame is full
//   out_valid   read beat valid
//   out_ready   downstream accept
//   out_data    LANES*DATA_W read beat
//   out_last    marks the final beat of the frame
//   frame_done  one-cycle pulse after the final read beat is accepted
// ---------------------------------------------------------------------------
module fmap_storage_buf #(
   parameter int DATA_W = 32,
   parameter int CH     = 16,
   parameter int FH     = 10,
   parameter int FW     = 10,
   parameter int LANES  = 2,
   parameter int ADDR_W = $clog2(CH*FH*FW)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    soft_clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    frame_full,
   input  logic                    rd_start,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic                    out_last,
   output logic                    frame_done
);

   localparam int DEPTH  = CH*FH*FW;
   localparam int ROWS   = DEPTH / LANES;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BEAT_W = LANES*DATA_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - LANES);
   // Only used when a frame spans more than one beat, so the truncation that
   // happens for LANES == DEPTH is never observed.
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(LANES);

   if (DEPTH % LANES != 0) begin : g_depth_chk
      $fatal(1, "fmap_storage_buf: CH*FH*FW must be a multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, WRITE, FULL, READ} state_t;

   // Pointers are word addresses that are always a multiple of LANES, so
   // the RAM is organised as one row per beat.
   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] ptr);
      return ROW_W'(int'(ptr) / LANES);
   endfunction

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
   logic                issue_done;
   logic [BEAT_W-1:0]   mem [ROWS];

   logic                wr_fire, pop, last_pop, issue, p1_move, skid_load;
   logic                vld_p1, last_p1;
   logic [BEAT_W-1:0]   data_p1;
   logic                skid_vld, skid_last;
   logic [BEAT_W-1:0]   skid_data;

   // in_ready is a registered copy of "state is IDLE or WRITE", so it is
   // low during reset and can gate the write directly.
   assign wr_fire   = in_valid & in_ready & ~soft_clr;
   assign pop       = out_valid & out_ready;
   assign last_pop  = pop & out_last;
   // The RAM read register may only be refilled when its current beat can
   // move on; the output stage accepts whenever its skid slot is empty.
   assign p1_move   = vld_p1 & ~skid_vld;
   assign issue     = (state == READ) & ~issue_done & (~vld_p1 | p1_move) & ~soft_clr;
   assign skid_load = p1_move & ~pop & out_valid & ~soft_clr;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, WRITE: if (wr_fire) state_nxt = (wr_ptr == LAST_PTR) ? FULL : WRITE;
         FULL:        if (rd_start) state_nxt = READ;
         READ:        if (last_pop) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
      if (soft_clr) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         issue_done <= 1'b0;
         in_ready   <= 1'b0;
         frame_full <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         in_ready   <= (state_nxt == IDLE) || (state_nxt == WRITE);
         frame_full <= (state_nxt == FULL) || (state_nxt == READ);
         frame_done <= last_pop & ~soft_clr;
         if (soft_clr || last_pop) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            issue_done <= 1'b0;
         end else begin
            if (wr_fire && (wr_ptr != LAST_PTR)) wr_ptr <= wr_ptr + STEP;
            if ((state == FULL) && rd_start) begin
               rd_ptr     <= '0;
               issue_done <= 1'b0;
            end else if (issue) begin
               if (rd_ptr == LAST_PTR) issue_done <= 1'b1;
               else                    rd_ptr     <= rd_ptr + STEP;
            end
         end
      end
   end

   // ---- stage p0 -> p1: RAM write and synchronous RAM read ----
   always_ff @(posedge clk) begin
      if (wr_fire) mem[row_of(wr_ptr)] <= in_data;
      if (issue)   data_p1 <= mem[row_of(rd_ptr)];
      if (skid_load) skid_data <= data_p1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (soft_clr) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (issue) begin
         vld_p1  <= 1'b1;
         last_p1 <= (rd_ptr == LAST_PTR);
      end else if (p1_move) begin
         vld_p1  <= 1'b0;
      end
   end

   // ---- stage p1 -> p2: output register with one-beat skid ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         skid_vld  <= 1'b0;
         skid_last <= 1'b0;
      end else if (soft_clr) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         skid_vld  <= 1'b0;
         skid_last <= 1'b0;
      end else if (pop) begin
         if (skid_vld) begin
            out_data <= skid_data;
            out_last <= skid_last;
            skid_vld <= 1'b0;
         end else if (p1_move) begin
            out_data <= data_p1;
            out_last <= last_p1;
         end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end else if (p1_move) begin
         if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= data_p1;
            out_last  <= last_p1;
         end else begin
            skid_vld  <= 1'b1;
            skid_last <= last_p1;
         end
      end
   end

endmodule
